// File: rtl/op_centric_packer.sv
// Packs p_ratio narrow items popped from an upstream queue into one wide word
// (first item in the LSBs) and pushes it downstream; a flush emits a partial word.
module op_centric_packer #(
    parameter int p_bitwidth = 8,
    parameter int p_ratio    = 4,
    localparam int c_cnt_w   = $clog2(p_ratio + 1),
    localparam int c_out_w   = p_bitwidth * p_ratio
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  pop_front_en,
    input  logic                  pop_front_rdy,
    input  logic [p_bitwidth-1:0] pop_front_data,
    output logic                  push_back_en,
    input  logic                  push_back_rdy,
    output logic [c_out_w-1:0]    push_back_data,
    output logic [c_cnt_w-1:0]    push_back_count,
    input  logic                  flush
);

    typedef enum logic [1:0] {
        S_POP,
        S_CAP,
        S_PUSH
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   idx_q, idx_d;
    logic [c_out_w-1:0]   pack_q, pack_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 flush_req_eff;

    // A flush only matters when at least one lane holds data.
    assign flush_req_eff = (flush | flush_pend_q) & (idx_q != '0);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pack_d       = pack_q;
        flush_pend_d = flush_pend_q;
        pop_front_en = 1'b0;
        push_back_en = 1'b0;

        case (state_q)
            S_POP: begin
                pop_front_en = ~flush_req_eff & pop_front_rdy & ~rst;
                if (flush_req_eff) begin
                    state_d      = S_PUSH;
                    flush_pend_d = 1'b0;
                end else if (pop_front_en) begin
                    state_d = S_CAP;
                end
            end

            // Popped data arrives one cycle after the pop edge, so it is captured here.
            S_CAP: begin
                for (int l = 0; l < p_ratio; l++) begin
                    if (idx_q == c_cnt_w'(l)) begin
                        pack_d[l*p_bitwidth +: p_bitwidth] = pop_front_data;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == c_cnt_w'(p_ratio - 1)) begin
                    state_d      = S_PUSH;
                    flush_pend_d = 1'b0;
                end else begin
                    state_d = S_POP;
                    if (flush) begin
                        flush_pend_d = 1'b1;
                    end
                end
            end

            S_PUSH: begin
                push_back_en = push_back_rdy & ~rst;
                if (push_back_en) begin
                    pack_d  = '0;
                    idx_d   = '0;
                    state_d = S_POP;
                end
            end

            default: begin
                state_d = S_POP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_POP;
            idx_q        <= '0;
            pack_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pack_q       <= pack_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign push_back_data  = rst ? '0 : pack_q;
    assign push_back_count = rst ? '0 : idx_q;

endmodule
